risc_mc_control: RTL and testbench

//  Multicycle control sequencer for the RiSC-16 datapath; successor to the single-cycle decoder.

---
 rtl/risc_mc_control.sv | 201 ++++++++++++++++++++
 tb/tb_risc_mc_control.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_mc_control.sv
// Multicycle control sequencer for the RiSC-16 datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with variable-latency memory and counts retirements.
module risc_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             eq_out,
  input  logic             mem_ready,
  input  logic             hold,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             we_reg,
  output logic [1:0]       wb_src,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             ADD,
  output logic             NAND,
  output logic             PASS1,
  output logic             EQ,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_LW   = 3'b100,
    OP_SW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  // Counter only ever needs to reach MEM_TIMEOUT-1 before the timeout fires.
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_retired;
  logic               r_timeout_err;

  state_t             w_next_state;
  logic               w_waiting;
  logic               w_timeout;
  opcode_t            w_op;

  assign w_op = opcode_t'(opcode);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_waiting    = 1'b0;
    w_timeout    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    we_reg       = 1'b0;
    wb_src       = 2'd0;
    pc_load      = 1'b0;
    pc_src       = 2'd0;
    ADD          = 1'b0;
    NAND         = 1'b0;
    PASS1        = 1'b0;
    EQ           = 1'b0;

    if (!hold) begin
      case (r_state)
        S_IDLE: w_next_state = S_FETCH;

        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load      = 1'b1;
            w_next_state = S_DECODE;
          end else begin
            w_waiting = 1'b1;
          end
        end

        S_DECODE: w_next_state = S_EXEC;

        S_EXEC: begin
          case (w_op)
            OP_ADD, OP_ADDI: begin
              ADD          = 1'b1;
              w_next_state = S_WB;
            end
            OP_NAND: begin
              NAND         = 1'b1;
              w_next_state = S_WB;
            end
            OP_LUI: begin
              PASS1        = 1'b1;
              w_next_state = S_WB;
            end
            OP_LW, OP_SW: begin
              ADD          = 1'b1;
              w_next_state = S_MEM;
            end
            OP_BEQ: begin
              EQ           = 1'b1;
              pc_load      = 1'b1;
              pc_src       = eq_out ? 2'd1 : 2'd0;
              w_next_state = S_FETCH;
            end
            OP_JALR: begin
              PASS1        = 1'b1;
              we_reg       = 1'b1;
              wb_src       = 2'd2;
              pc_load      = 1'b1;
              pc_src       = 2'd2;
              w_next_state = S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          ADD     = 1'b1;
          mem_req = 1'b1;
          mem_we  = (w_op == OP_SW);
          if (mem_ready) begin
            if (w_op == OP_SW) begin
              pc_load      = 1'b1;
              w_next_state = S_FETCH;
            end else begin
              mdr_load     = 1'b1;
              w_next_state = S_WB;
            end
          end else begin
            w_waiting = 1'b1;
          end
        end

        S_WB: begin
          we_reg       = 1'b1;
          wb_src       = (w_op == OP_LW) ? 2'd1 : 2'd0;
          pc_load      = 1'b1;
          w_next_state = S_FETCH;
        end

        S_ERROR: w_next_state = S_ERROR;

        default: w_next_state = S_IDLE;
      endcase

      // A same-cycle mem_ready never reaches here, so it always beats the timeout.
      if (TIMEOUT_EN && w_waiting && (r_wait_cnt == WAIT_LAST)) begin
        w_timeout    = 1'b1;
        w_next_state = S_ERROR;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_retired     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (!hold) begin
        r_wait_cnt <= (w_waiting && !w_timeout) ? r_wait_cnt + WAIT_W'(1) : '0;
      end
      if (pc_load) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign state_o     = r_state;
  assign retired     = r_retired;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_risc_mc_control.sv
// Bench for risc_mc_control: per-instruction expected cycle traces built from the
// instruction-level rules, replayed with random memory latency, holds and don't-care inputs.
`timescale 1ns/1ps
module tb_risc_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       eq_out = 1'b0;
  logic       mem_ready = 1'b0;
  logic       hold = 1'b1;

  logic a_mem_req, a_mem_we, a_ir_load, a_mdr_load, a_we_reg, a_pc_load;
  logic a_ADD, a_NAND, a_PASS1, a_EQ, a_terr;
  logic [1:0] a_wb_src, a_pc_src;
  logic [2:0] a_state;
  logic [31:0] a_retired;

  logic b_mem_req, b_mem_we, b_ir_load, b_mdr_load, b_we_reg, b_pc_load;
  logic b_ADD, b_NAND, b_PASS1, b_EQ, b_terr;
  logic [1:0] b_wb_src, b_pc_src;
  logic [2:0] b_state;
  logic [2:0] b_retired;

  risc_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .eq_out(eq_out), .mem_ready(mem_ready), .hold(hold),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .ir_load(a_ir_load), .mdr_load(a_mdr_load),
    .we_reg(a_we_reg), .wb_src(a_wb_src), .pc_load(a_pc_load), .pc_src(a_pc_src),
    .ADD(a_ADD), .NAND(a_NAND), .PASS1(a_PASS1), .EQ(a_EQ), .state_o(a_state),
    .retired(a_retired), .timeout_err(a_terr)
  );

  risc_mc_control #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_t4 (
    .clk(clk), .rst(rst), .opcode(opcode), .eq_out(eq_out), .mem_ready(mem_ready), .hold(hold),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .ir_load(b_ir_load), .mdr_load(b_mdr_load),
    .we_reg(b_we_reg), .wb_src(b_wb_src), .pc_load(b_pc_load), .pc_src(b_pc_src),
    .ADD(b_ADD), .NAND(b_NAND), .PASS1(b_PASS1), .EQ(b_EQ), .state_o(b_state),
    .retired(b_retired), .timeout_err(b_terr)
  );

  always #5 clk = ~clk;

  // Output word: [16]req [15]we [14]ir [13]mdr [12]wreg [11:10]wb_src [9]pc_load
  // [8:7]pc_src [6]ADD [5]NAND [4]PASS1 [3]EQ [2:0]state
  localparam logic [16:0] REQ = 17'h10000, WE = 17'h08000, IR = 17'h04000, MDR = 17'h02000;
  localparam logic [16:0] WREG = 17'h01000, PCL = 17'h00200;
  localparam logic [16:0] B_ADD = 17'h00040, B_NAND = 17'h00020, B_PASS = 17'h00010, B_EQ = 17'h00008;

  wire [16:0] obs_a = {a_mem_req, a_mem_we, a_ir_load, a_mdr_load, a_we_reg, a_wb_src, a_pc_load,
                       a_pc_src, a_ADD, a_NAND, a_PASS1, a_EQ, a_state};
  wire [16:0] obs_b = {b_mem_req, b_mem_we, b_ir_load, b_mdr_load, b_we_reg, b_wb_src, b_pc_load,
                       b_pc_src, b_ADD, b_NAND, b_PASS1, b_EQ, b_state};

  typedef struct {
    logic        rdy;
    logic        hld;
    logic        eq;
    logic [2:0]  op;
    logic [16:0] exp;
  } cyc_t;

  cyc_t        trace[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_ret = 0;
  logic        exp_terr = 1'b0;
  bit          use_t4 = 1'b0;
  string       cur = "init";

  function automatic logic [16:0] st(input int s);
    return 17'(s);
  endfunction
  function automatic logic [16:0] wsrc(input int v);
    return 17'(v) << 10;
  endfunction
  function automatic logic [16:0] psrc(input int v);
    return 17'(v) << 7;
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic eq, input logic [2:0] op, input logic [16:0] e);
    cyc_t c;
    c.rdy = rdy; c.hld = 1'b0; c.eq = eq; c.op = op; c.exp = e;
    trace.push_back(c);
  endtask

  // Expected cycles of one instruction; memory answers on the f_lat-th FETCH cycle
  // and the m_lat-th MEM cycle.
  task automatic build_instr(input logic [2:0] op, input int f_lat, input int m_lat, input logic beq_eq);
    logic [16:0] e;
    for (int i = 1; i <= f_lat; i++)
      push(i == f_lat, rb(), 3'($urandom_range(0, 7)), (i == f_lat) ? (st(1) | REQ | IR) : (st(1) | REQ));
    push(rb(), rb(), op, st(2));
    case (op)
      3'd0, 3'd1, 3'd4, 3'd5: push(rb(), rb(), op, st(3) | B_ADD);
      3'd2: push(rb(), rb(), op, st(3) | B_NAND);
      3'd3: push(rb(), rb(), op, st(3) | B_PASS);
      3'd6: push(rb(), beq_eq, op, st(3) | B_EQ | PCL | psrc(beq_eq ? 1 : 0));
      default: push(rb(), rb(), op, st(3) | B_PASS | WREG | wsrc(2) | PCL | psrc(2));
    endcase
    if (op == 3'd4 || op == 3'd5) begin
      for (int i = 1; i <= m_lat; i++) begin
        e = st(4) | REQ | B_ADD | ((op == 3'd5) ? WE : 17'h0);
        if (i == m_lat) e = e | ((op == 3'd4) ? MDR : PCL);
        push(i == m_lat, rb(), op, e);
      end
    end
    if (op <= 3'd4) push(rb(), rb(), op, st(5) | WREG | wsrc((op == 3'd4) ? 1 : 0) | PCL);
  endtask

  // Frozen cycles: state visible, every strobe low, mem_ready irrelevant.
  task automatic insert_hold(input int idx, input int n, input bit rdy_one);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c.rdy = rdy_one ? 1'b1 : rb();
      c.hld = 1'b1;
      c.eq  = rb();
      c.op  = trace[idx].op;
      c.exp = trace[idx].exp & 17'h00007;
      trace.insert(idx, c);
    end
  endtask

  // Replays n queued cycles (all when n < 0), comparing at mid-cycle.
  task automatic run_trace(input int n);
    cyc_t        c;
    logic [16:0] obs;
    logic [31:0] ret_obs, ret_exp;
    logic        terr_obs;
    int          done = 0;
    while (trace.size() > 0 && (n < 0 || done < n)) begin
      c = trace.pop_front();
      done++;
      @(negedge clk);
      mem_ready = c.rdy; hold = c.hld; eq_out = c.eq; opcode = c.op;
      #1;
      obs      = use_t4 ? obs_b : obs_a;
      ret_obs  = use_t4 ? 32'(b_retired) : a_retired;
      ret_exp  = use_t4 ? (exp_ret & 32'h7) : exp_ret;
      terr_obs = use_t4 ? b_terr : a_terr;
      vectors++;
      if (obs !== c.exp) begin
        miscompares++;
        $display("FAIL %s outputs @%0t: got %h expected %h", cur, $time, obs, c.exp);
      end
      vectors++;
      if (ret_obs !== ret_exp) begin
        miscompares++;
        $display("FAIL %s retired @%0t: got %0d expected %0d", cur, $time, ret_obs, ret_exp);
      end
      vectors++;
      if (terr_obs !== exp_terr) begin
        miscompares++;
        $display("FAIL %s timeout_err @%0t: got %b expected %b", cur, $time, terr_obs, exp_terr);
      end
      if (!c.hld && c.exp[9]) exp_ret = exp_ret + 32'd1;
    end
  endtask

  // Asynchronous reset away from any edge; leaves one held and one free IDLE cycle queued.
  task automatic do_reset();
    cyc_t c;
    @(negedge clk);
    #2;
    rst = 1'b1; hold = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if ((use_t4 ? obs_b : obs_a) !== 17'h0) begin
      miscompares++;
      $display("FAIL %s reset outputs: got %h expected 0", cur, use_t4 ? obs_b : obs_a);
    end
    vectors++;
    if ((use_t4 ? 32'(b_retired) : a_retired) !== 32'd0 || (use_t4 ? b_terr : a_terr) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s reset counters: got retired %0d err %b expected 0 0", cur,
               use_t4 ? 32'(b_retired) : a_retired, use_t4 ? b_terr : a_terr);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0; exp_terr = 1'b0;
    trace.delete();
    c.rdy = 1'b1; c.hld = 1'b1; c.eq = 1'b0; c.op = 3'd0; c.exp = st(0);
    trace.push_back(c);
    c.hld = 1'b0;
    trace.push_back(c);
  endtask

  task automatic test_reset();
    cur = "reset"; use_t4 = 1'b0;
    do_reset();
    run_trace(-1);
  endtask

  task automatic test_add();
    cur = "add";
    build_instr(3'd0, 1, 1, 1'b0);
    run_trace(-1);
  endtask

  task automatic test_lw_latency();
    cur = "lw_latency";
    build_instr(3'd4, 1, 3, 1'b0);
    run_trace(-1);
  endtask

  task automatic test_beq();
    cur = "beq";
    build_instr(3'd6, 2, 1, 1'b1);
    build_instr(3'd6, 1, 1, 1'b0);
    run_trace(-1);
  endtask

  task automatic test_latency_boundary();
    cur = "latency_boundary";
    build_instr(3'd4, 16, 16, 1'b0);
    build_instr(3'd5, 16, 16, 1'b0);
    run_trace(-1);
  endtask

  task automatic test_hold_mem();
    cur = "hold_mem";
    build_instr(3'd5, 1, 2, 1'b0);
    insert_hold(3, 5, 1'b1);
    run_trace(-1);
  endtask

  task automatic test_random();
    logic [2:0] op;
    int         base;
    cur = "random";
    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom_range(0, 7));
      base = trace.size();
      build_instr(op,
                  ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(1, 5)),
                  ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(1, 5)),
                  rb());
      for (int i = trace.size() - 1; i >= base; i--)
        if ($urandom_range(0, 9) == 0) insert_hold(i, int'($urandom_range(1, 3)), 1'b0);
      run_trace(-1);
    end
  endtask

  task automatic test_reset_mid_mem();
    cur = "reset_mid_mem";
    do_reset();
    build_instr(3'd0, 1, 1, 1'b0);
    build_instr(3'd5, 1, 10, 1'b0);
    run_trace(trace.size() - 8);
    do_reset();
    build_instr(3'd7, 1, 1, 1'b0);
    run_trace(-1);
  endtask

  task automatic test_wrap_t4();
    cur = "wrap_t4"; use_t4 = 1'b1;
    do_reset();
    for (int n = 0; n < 9; n++) build_instr(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 4, rb());
    run_trace(-1);
  endtask

  task automatic test_timeout_t4();
    cyc_t c;
    cur = "timeout_t4"; use_t4 = 1'b1;
    do_reset();
    run_trace(-1);
    for (int i = 0; i < 4; i++) push(1'b0, rb(), 3'd0, st(1) | REQ);
    run_trace(-1);
    exp_terr = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, rb(), 3'd5, st(7));
    c.rdy = 1'b1; c.hld = 1'b1; c.eq = 1'b0; c.op = 3'd0; c.exp = st(7);
    trace.push_back(c);
    run_trace(-1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_latency();
    test_beq();
    test_latency_boundary();
    test_hold_mem();
    test_random();
    test_reset_mid_mem();
    test_wrap_t4();
    test_timeout_t4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
